dna_read_ctrl: RTL and testbench

DNA_READ_CTRL -- requirements
Module: dna_read_ctrl

---
 rtl/dna_read_ctrl.sv | 122 ++++++++++++
 tb/tb_dna_read_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dna_read_ctrl.sv
// Device DNA readout sequencer: LOAD pulse, then shifts DNA_WIDTH bits from DNA_PORT.
// Define DNA_AUTOSTART_EN to start one readout automatically after each reset.
module dna_read_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int DNA_WIDTH = 57
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 dna_valid,
  output logic [DNA_WIDTH-1:0] dna_value,
  output logic                 dna_clk,
  output logic                 dna_read,
  output logic                 dna_shift,
  output logic                 dna_din,
  input  logic                 dna_dout
);

  localparam int BW = $clog2(DNA_WIDTH + 1);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] DIV_FIRST = (CLK_DIV == 1) ? 8'd0 : 8'd1;
  localparam logic CLK_FIRST = (CLK_DIV == 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DNA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t               state;
  logic [7:0]           div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DNA_WIDTH-1:0] cap;
  logic                 req;
  logic                 div_hit;

`ifdef DNA_AUTOSTART_EN
  logic auto_pend;
  assign req = start | auto_pend;
`else
  assign req = start;
`endif

  assign dna_din = 1'b0;
  assign div_hit = (div_cnt == DIV_LAST);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      cap       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dna_valid <= 1'b0;
      dna_value <= '0;
      dna_clk   <= 1'b0;
      dna_read  <= 1'b0;
      dna_shift <= 1'b0;
`ifdef DNA_AUTOSTART_EN
      auto_pend <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
`ifdef DNA_AUTOSTART_EN
      auto_pend <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (req) begin
            state     <= LOAD;
            busy      <= 1'b1;
            dna_valid <= 1'b0;
            cap       <= '0;
            div_cnt   <= DIV_FIRST;
            bit_cnt   <= '0;
            dna_read  <= 1'b1;
            dna_shift <= 1'b0;
            // with CLK_DIV=1 the first rise coincides with the accept edge
            dna_clk   <= CLK_FIRST;
          end
        end
        LOAD, SHIFT: begin
          div_cnt <= div_hit ? 8'd0 : div_cnt + 8'd1;
          if (div_hit) begin
            dna_clk <= ~dna_clk;
            if (dna_clk) begin
              cap     <= {cap[DNA_WIDTH-2:0], dna_dout};
              bit_cnt <= bit_cnt + BIT_ONE;
              if (bit_cnt == BIT_LAST)
                state <= DONE;
            end
          end
          // READ stays up for the whole first dna_clk period
          if (state == LOAD && !dna_clk && bit_cnt == BIT_ONE) begin
            state     <= SHIFT;
            dna_read  <= 1'b0;
            dna_shift <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          dna_valid <= 1'b1;
          dna_value <= cap;
          dna_read  <= 1'b0;
          dna_shift <= 1'b0;
          div_cnt   <= '0;
          bit_cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_read_ctrl.sv
// Directed bench for dna_read_ctrl with behavioral DNA_PORT models.
// Covers CLK_DIV=4 and CLK_DIV=1; DNA_AUTOSTART_EN selects the autostart test.
module tb_dna_read_ctrl;

  localparam logic [56:0] DNA = 57'h0123456789ABCDE;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic ARESET = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;

  logic        busy, done, dna_valid, dna_clk, dna_read, dna_shift, dna_din, dna_dout;
  logic [56:0] dna_value;
  logic        busy1, done1, dna_valid1, dna_clk1, dna_read1, dna_shift1, dna_din1, dna_dout1;
  logic [56:0] dna_value1;

  dna_read_ctrl #(.CLK_DIV(4), .DNA_WIDTH(57)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start),
    .busy(busy), .done(done), .dna_valid(dna_valid), .dna_value(dna_value),
    .dna_clk(dna_clk), .dna_read(dna_read), .dna_shift(dna_shift),
    .dna_din(dna_din), .dna_dout(dna_dout)
  );

  dna_read_ctrl #(.CLK_DIV(1), .DNA_WIDTH(57)) dut1 (
    .ACLK(ACLK), .ARESET(ARESET), .start(start1),
    .busy(busy1), .done(done1), .dna_valid(dna_valid1), .dna_value(dna_value1),
    .dna_clk(dna_clk1), .dna_read(dna_read1), .dna_shift(dna_shift1),
    .dna_din(dna_din1), .dna_dout(dna_dout1)
  );

  // DNA_PORT models: READ/SHIFT are taken as seen during the dna_clk high cycle
  logic [56:0] sr0 = '0;
  logic [56:0] sr1 = '0;
  assign dna_dout  = sr0[56];
  assign dna_dout1 = sr1[56];

  always @(posedge dna_clk) begin
    #1;
    if (dna_read) sr0 = DNA;
    else if (dna_shift) sr0 = {sr0[55:0], dna_din};
  end

  always @(posedge dna_clk1) begin
    #1;
    if (dna_read1) sr1 = DNA;
    else if (dna_shift1) sr1 = {sr1[55:0], dna_din1};
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  typedef struct {
    int   cyc;
    logic busy;
    logic read;
    logic shift;
    logic clk;
    logic done;
    logic valid;
  } vec_t;

  localparam int NT = 12;
  vec_t tbl[NT];

  task automatic run4(input int ra, input int rb, input bit use_tbl,
                      output int done_cyc, output int ndone, output int rises,
                      output int r1, output int s1, output int both);
    int   idx;
    logic pclk;
    idx = 0;
    pclk = 1'b0;
    done_cyc = -1;
    ndone = 0;
    rises = 0;
    r1 = 0;
    s1 = 0;
    both = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 480; c++) begin
      if (use_tbl && idx < NT && tbl[idx].cyc == c) begin
        chk($sformatf("c%0d busy", c), 64'(busy), 64'(tbl[idx].busy));
        chk($sformatf("c%0d read", c), 64'(dna_read), 64'(tbl[idx].read));
        chk($sformatf("c%0d shift", c), 64'(dna_shift), 64'(tbl[idx].shift));
        chk($sformatf("c%0d clk", c), 64'(dna_clk), 64'(tbl[idx].clk));
        chk($sformatf("c%0d done", c), 64'(done), 64'(tbl[idx].done));
        chk($sformatf("c%0d valid", c), 64'(dna_valid), 64'(tbl[idx].valid));
        idx++;
      end
      if (dna_clk && !pclk) begin
        rises++;
        if (dna_read) r1++;
        if (dna_shift) s1++;
        if (dna_read && dna_shift) both++;
      end
      pclk = dna_clk;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      start = (c == ra || c == rb);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " valid"}, 64'(dna_valid), 64'd0);
    chk({tag, " value"}, 64'(dna_value), 64'd0);
    chk({tag, " clk"}, 64'(dna_clk), 64'd0);
    chk({tag, " read"}, 64'(dna_read), 64'd0);
    chk({tag, " shift"}, 64'(dna_shift), 64'd0);
    chk({tag, " din"}, 64'(dna_din), 64'd0);
  endtask

  int dc, nd, rs, r1, s1, bo;
  int dc1, vbad;
  logic [56:0] v_at;
  logic        val_at;

  initial begin
    tbl[0]  = '{1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{7,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{8,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{9,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{12,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{16,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{452, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{456, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{457, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{458, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    ARESET = 1'b1;
    repeat (3) tick();
    chk_zero("reset");

`ifdef DNA_AUTOSTART_EN
    ARESET = 1'b0;
    dc = -1;
    dc1 = -1;
    for (int c = 1; c <= 480; c++) begin
      tick();
      if (done && dc < 0) begin
        dc = c;
        v_at = dna_value;
      end
      if (done1 && dc1 < 0) dc1 = c;
    end
    chk("auto done cycle", 64'(dc), 64'd457);
    chk("auto value", 64'(v_at), 64'(DNA));
    chk("auto valid", 64'(dna_valid), 64'd1);
    chk("auto div1 done cycle", 64'(dc1), 64'd115);
    chk("auto div1 value", 64'(dna_value1), 64'(DNA));
`else
    ARESET = 1'b0;
    repeat (5) tick();
    chk("idle busy", 64'(busy), 64'd0);
    chk("idle valid", 64'(dna_valid), 64'd0);

    run4(-1, -1, 1'b1, dc, nd, rs, r1, s1, bo);
    chk("run done cycle", 64'(dc), 64'd457);
    chk("run done count", 64'(nd), 64'd1);
    chk("run value", 64'(dna_value), 64'(DNA));
    chk("run valid", 64'(dna_valid), 64'd1);
    chk("rises", 64'(rs), 64'd57);
    chk("rises read", 64'(r1), 64'd1);
    chk("rises shift", 64'(s1), 64'd56);
    chk("rises both", 64'(bo), 64'd0);

    run4(100, 300, 1'b0, dc, nd, rs, r1, s1, bo);
    chk("restart done cycle", 64'(dc), 64'd457);
    chk("restart done count", 64'(nd), 64'd1);
    chk("restart value", 64'(dna_value), 64'(DNA));

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 200; c++) tick();
    chk("pre-reset busy", 64'(busy), 64'd1);
    ARESET = 1'b1;
    start = 1'b1;
    tick();
    ARESET = 1'b0;
    start = 1'b0;
    chk_zero("midreset");
    tick();
    chk("reset start ignored", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("reset idle valid", 64'(dna_valid), 64'd0);
    run4(-1, -1, 1'b0, dc, nd, rs, r1, s1, bo);
    chk("post-reset done cycle", 64'(dc), 64'd457);
    chk("post-reset value", 64'(dna_value), 64'(DNA));

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      dc1 = -1;
      vbad = 0;
      v_at = '0;
      val_at = 1'b0;
      for (int c = 1; c <= 200 && dc1 < 0; c++) begin
        if (done1) begin
          dc1 = c;
          v_at = dna_value1;
          val_at = dna_valid1;
          start1 = (r < 2);
        end else if (dna_valid1) begin
          vbad++;
        end
        tick();
      end
      start1 = 1'b0;
      chk($sformatf("div1 r%0d done cycle", r), 64'(dc1), 64'd115);
      chk($sformatf("div1 r%0d valid low", r), 64'(vbad), 64'd0);
      chk($sformatf("div1 r%0d valid", r), 64'(val_at), 64'd1);
      chk($sformatf("div1 r%0d value", r), 64'(v_at), 64'(DNA));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
